cv32e40p_wb_arbiter: RTL and testbench



---
 rtl/cv32e40p_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_cv32e40p_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_wb_arbiter.sv
// Writeback arbiter: EX results pass straight to RF port A, LSU results drain from a FIFO onto port B.
// Optional pending-write scoreboard with hazard outputs, built when CV32E40P_WB_SCOREBOARD_EN is defined.
module cv32e40p_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o
);

    // Depth is 2 or 4, so pointers wrap naturally at their width.
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] waddr_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] waddr_mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] dead_q, dead_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  push, pop, head_valid, head_dead, collide;
    logic [ADDR_WIDTH-1:0] head_waddr;
    logic [DATA_WIDTH-1:0] head_wdata;

    assign we_a_o    = ex_valid_i && (ex_waddr_i != '0);
    assign waddr_a_o = ex_waddr_i;
    assign wdata_a_o = ex_wdata_i;

    assign lsu_ready_o = count_q < CNT_W'(FIFO_DEPTH);
    assign push        = lsu_valid_i && lsu_ready_o;
    assign head_valid  = count_q != '0;
    assign pop         = head_valid;
    assign head_waddr  = waddr_mem_q[rd_ptr_q];
    assign head_wdata  = wdata_mem_q[rd_ptr_q];
    assign head_dead   = dead_q[rd_ptr_q];

    // EX is younger than anything queued, so a same-register head entry is dropped.
    assign collide   = we_a_o && (waddr_a_o == head_waddr);
    assign we_b_o    = head_valid && !head_dead && !collide;
    assign waddr_b_o = head_valid ? head_waddr : '0;
    assign wdata_b_o = head_valid ? head_wdata : '0;

    always_comb begin
        waddr_mem_d = waddr_mem_q;
        wdata_mem_d = wdata_mem_q;
        dead_d      = dead_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            waddr_mem_d[wr_ptr_q] = lsu_waddr_i;
            wdata_mem_d[wr_ptr_q] = lsu_wdata_i;
            dead_d[wr_ptr_q]      = (lsu_waddr_i == '0);
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                waddr_mem_q[i] <= '0;
                wdata_mem_q[i] <= '0;
            end
            dead_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            waddr_mem_q <= waddr_mem_d;
            wdata_mem_q <= wdata_mem_d;
            dead_q      <= dead_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef CV32E40P_WB_SCOREBOARD_EN
    logic [2**ADDR_WIDTH-1:0] sb_q, sb_d;

    // Clear on pop first so a same-cycle issue to the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (pop) begin
            sb_d[head_waddr] = 1'b0;
        end
        if (issue_i && (issue_waddr_i != '0)) begin
            sb_d[issue_waddr_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign hazard_a_o = sb_q[raddr_a_i];
    assign hazard_b_o = sb_q[raddr_b_i];
    assign hazard_c_o = sb_q[raddr_c_i];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_i, issue_waddr_i, raddr_a_i, raddr_b_i, raddr_c_i};
    assign hazard_a_o = 1'b0;
    assign hazard_b_o = 1'b0;
    assign hazard_c_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Bench for cv32e40p_wb_arbiter: queue-based reference model, per-cycle compare, directed literal checks.
module tb_cv32e40p_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk, rst_n;
  logic          ex_valid_i, lsu_valid_i, lsu_ready_o, issue_i;
  logic [AW-1:0] ex_waddr_i, lsu_waddr_i, issue_waddr_i;
  logic [DW-1:0] ex_wdata_i, lsu_wdata_i;
  logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
  logic          hazard_a_o, hazard_b_o, hazard_c_o;
  logic          we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t        q[$];
  logic [31:0]   sb_m;

  cv32e40p_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .issue_i(issue_i), .issue_waddr_i(issue_waddr_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .hazard_c_o(hazard_c_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, the scoreboard a bit vector.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      sb_m = '0;
    end else begin
      bit     do_push;
      entry_t e;
      do_push = lsu_valid_i && (q.size() < DEPTH);
      if (q.size() > 0) begin
        e = q.pop_front();
        sb_m[e.a] = 1'b0;
      end
      if (issue_i && issue_waddr_i != 0) sb_m[issue_waddr_i] = 1'b1;
      if (do_push) begin
        e.a = lsu_waddr_i;
        e.d = lsu_wdata_i;
        q.push_back(e);
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      logic          exp_we_a, exp_we_b, hv;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      hv = q.size() > 0;
      ha = hv ? q[0].a : '0;
      hd = hv ? q[0].d : '0;
      exp_we_a = ex_valid_i && ex_waddr_i != 0;
      exp_we_b = hv && ha != 0 && !(exp_we_a && ex_waddr_i == ha);
      check("we_a", we_a_o, exp_we_a);
      check("waddr_a", waddr_a_o, ex_waddr_i);
      check("wdata_a", wdata_a_o, ex_wdata_i);
      check("we_b", we_b_o, exp_we_b);
      check("waddr_b", waddr_b_o, ha);
      check("wdata_b", wdata_b_o, hd);
      check("lsu_ready", lsu_ready_o, q.size() < DEPTH);
`ifdef CV32E40P_WB_SCOREBOARD_EN
      check("hazard_a", hazard_a_o, sb_m[raddr_a_i]);
      check("hazard_b", hazard_b_o, sb_m[raddr_b_i]);
      check("hazard_c", hazard_c_o, sb_m[raddr_c_i]);
`else
      check("hazard_a", hazard_a_o, 1'b0);
      check("hazard_b", hazard_b_o, 1'b0);
      check("hazard_c", hazard_c_o, 1'b0);
`endif
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    issue_i = 0; issue_waddr_i = 0;
    raddr_a_i = 0; raddr_b_i = 0; raddr_c_i = 0;
  endtask

  task automatic lsu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lsu_valid_i = 1; lsu_waddr_i = a; lsu_wdata_i = d;
  endtask

  initial begin
    bit hold;
    idle();
    rst_n = 0;
    ex_valid_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'h1234;
    @(negedge clk);
    check("rst_we_a", we_a_o, 1'b1);
    check("rst_we_b", we_b_o, 1'b0);
    check("rst_waddr_b", waddr_b_o, 0);
    check("rst_wdata_b", wdata_b_o, 0);
    check("rst_ready", lsu_ready_o, 1'b1);
    check("rst_hazard_a", hazard_a_o, 1'b0);
    next_cycle();
    idle();
    rst_n = 1;

    // single LSU write appears on port B one cycle later, then retires
    next_cycle();
    lsu(5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_we_b_before", we_b_o, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1_we_b", we_b_o, 1'b1);
    check("t1_waddr_b", waddr_b_o, 5);
    check("t1_wdata_b", wdata_b_o, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_we_b_after", we_b_o, 1'b0);

    // EX collides with queued head on reg 7: EX wins, head dropped
    next_cycle();
    lsu(7, 32'hAA);
    issue_i = 1; issue_waddr_i = 7;
    next_cycle();
    idle();
    ex_valid_i = 1; ex_waddr_i = 7; ex_wdata_i = 32'h11;
    raddr_a_i = 7;
    @(negedge clk);
    check("t2_we_a", we_a_o, 1'b1);
    check("t2_wdata_a", wdata_a_o, 32'h11);
    check("t2_we_b", we_b_o, 1'b0);
`ifdef CV32E40P_WB_SCOREBOARD_EN
    check("t2_hazard_set", hazard_a_o, 1'b1);
`endif
    next_cycle();
    ex_valid_i = 0;
    @(negedge clk);
    check("t2_hazard_clr", hazard_a_o, 1'b0);
    check("t2_empty", waddr_b_o, 0);

    // register 0 on both paths writes nothing
    next_cycle();
    lsu(0, 32'h55);
    next_cycle();
    idle();
    ex_valid_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'h66;
    @(negedge clk);
    check("t3_we_a", we_a_o, 1'b0);
    check("t3_we_b", we_b_o, 1'b0);
    check("t3_waddr_b", waddr_b_o, 0);
    check("t3_wdata_b", wdata_b_o, 32'h55);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3_popped", wdata_b_o, 0);

    // scoreboard lifetime on reg 9, with a re-issue in the pop cycle
    next_cycle();
    issue_i = 1; issue_waddr_i = 9; raddr_b_i = 9;
    @(negedge clk);
    check("t4_no_bypass", hazard_b_o, 1'b0);
    next_cycle();
    issue_i = 0;
    lsu(9, 32'h99);
    @(negedge clk);
`ifdef CV32E40P_WB_SCOREBOARD_EN
    check("t4_hazard_set", hazard_b_o, 1'b1);
`else
    check("t4_hazard_off", hazard_b_o, 1'b0);
`endif
    next_cycle();
    lsu_valid_i = 0;
    issue_i = 1; issue_waddr_i = 9;
    @(negedge clk);
    check("t4_pop_we_b", we_b_o, 1'b1);
    next_cycle();
    issue_i = 0;
    lsu(9, 32'h9A);
    @(negedge clk);
`ifdef CV32E40P_WB_SCOREBOARD_EN
    check("t4_set_wins", hazard_b_o, 1'b1);
`endif
    next_cycle();
    lsu_valid_i = 0;
    next_cycle();
    @(negedge clk);
    check("t4_hazard_clr", hazard_b_o, 1'b0);

    // randomized traffic, LSU holds its request until accepted
    next_cycle();
    idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      hold = lsu_valid_i && !lsu_ready_o;
      next_cycle();
      ex_valid_i = ($urandom_range(0, 1) == 1);
      ex_waddr_i = AW'($urandom_range(0, 7));
      ex_wdata_i = $urandom;
      if (!hold) begin
        lsu_valid_i = ($urandom_range(0, 9) < 6);
        lsu_waddr_i = AW'($urandom_range(0, 7));
        lsu_wdata_i = $urandom;
      end
      issue_i       = ($urandom_range(0, 9) < 3);
      issue_waddr_i = AW'($urandom_range(0, 7));
      raddr_a_i     = AW'($urandom_range(0, 7));
      raddr_b_i     = AW'($urandom_range(0, 7));
      raddr_c_i     = AW'($urandom_range(0, 7));
    end

    // asynchronous reset with a queued entry and several pending bits
    next_cycle();
    idle();
    issue_i = 1; issue_waddr_i = 3;
    next_cycle();
    issue_waddr_i = 4;
    next_cycle();
    issue_waddr_i = 5;
    lsu(6, 32'h66);
    next_cycle();
    idle();
    raddr_a_i = 3; raddr_b_i = 4; raddr_c_i = 5;
    #1;
    check("t5_pre_we_b", we_b_o, 1'b1);
    #1;
    rst_n = 0;
    #1;
    check("t5_we_b", we_b_o, 1'b0);
    check("t5_waddr_b", waddr_b_o, 0);
    check("t5_wdata_b", wdata_b_o, 0);
    check("t5_ready", lsu_ready_o, 1'b1);
    check("t5_hazard_a", hazard_a_o, 1'b0);
    check("t5_hazard_b", hazard_b_o, 1'b0);
    check("t5_hazard_c", hazard_c_o, 1'b0);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    check("t5_after_we_b", we_b_o, 1'b0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
